mod_n_count_monitor: RTL and testbench
======================================

# mod_n_count_monitor

Cycle-accurate checker that sits at the receiving end of a `mod_N_counter`. It observes the same `i_en` / `i_up_down` controls the counter sees, plus the counter's `o_Q`. It maintains its own reference model of the count and flags any divergence or out-of-range value with sticky and per-cycle error outputs. It is instantiated alongside the counter in benches and in silicon self-test, and is synthesizable.

## Interface
- `WIDTH`, 2: count width; must equal the observed counter's `WIDTH`.
- `N`, 3: modulus; 2 ≤ N ≤ 2^WIDTH.
- `ERR_W`, 4: width of the saturating error counter.

- `i_clk` input 1: single clock, rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_en` input 1: count enable, same net as the counter's `i_en`.
- `i_up_down` input 1: direction, 1 = up, 0 = down; same net as the counter's.
- `i_Q` input WIDTH: observed counter output.
- `o_exp` output WIDTH: the model's expected count.
- `o_err_pulse` output 1: one-cycle flag for a mismatch detected in the previous cycle.
- `o_err` output 1: sticky error flag.
- `o_range_err` output 1: sticky flag, set when `i_Q ≥ N` is ever observed.
- `o_err_cnt` output ERR_W: count of mismatching cycles, saturating.
- `o_wrap` output 1: one-cycle pulse when the model wraps (N−1→0 going up, 0→N−1 going down).
- `o_state` output 2: FSM state, for debug.

## Operation
- Model update, on each rising edge with `i_rst` = 0:
  - `i_en` = 0: hold `o_exp`.
  - `i_en` = 1, up: `exp = (exp == N−1) ? 0 : exp+1`.
  - `i_en` = 1, down: `exp = (exp == 0) ? N−1 : exp−1`.
  - All arithmetic is in WIDTH bits. No value ≥ N is ever produced.
- Compare: combinational `mismatch = (i_Q != o_exp)` while in CHECK. A mismatch is registered into `o_err_pulse` at the next edge.
- Range: `i_Q ≥ N` in any non-reset cycle sets `o_range_err`. It also counts as a mismatch.
- FSM `o_state` encoding: CHECK = 2'b01, FAULT = 2'b10; 2'b00 is used only during the reset cycle.
  - CHECK → FAULT on mismatch. This sets `o_err` and increments `o_err_cnt`, saturating at 2^ERR_W−1.
  - FAULT: the model keeps tracking `i_en` / `i_up_down`. Comparison continues; each further mismatching cycle pulses and increments.
  - FAULT stays until `i_rst`, unless `MON_RESYNC_EN` is defined (see Configuration).
- Simultaneous wrap and mismatch: both pulses are asserted in the same cycle.

## Timing
- Reset: while `i_rst` = 1 at an edge, after that edge:
  - `o_exp` = 0, `o_state` = 2'b00.
  - `o_err_pulse`, `o_err`, `o_range_err`, `o_err_cnt`, `o_wrap` all = 0.
  - No comparison in that cycle.
- First edge after reset release: the state enters CHECK.
  - The `i_Q` vs `o_exp` comparison is active from the cycle following release.
  - `o_exp` tracks the counter register with 0 cycles skew: both update on the same edge from the same controls.
- Error latency: a mismatch in cycle k gives `o_err_pulse` = 1 in cycle k+1. `o_err` is set from k+1 onward.
- `o_wrap`: high in the cycle after the edge at which the model wrapped. Not asserted when `i_en` = 0.
- Reset mid-operation: clears every output, including sticky flags and the counter, at that edge regardless of state.
- `i_en` = 0 across many cycles: the model holds, and the comparison still runs each cycle.

## Configuration
- `MON_RESYNC_EN`
  - Defined: FAULT lasts exactly one cycle. The model reloads from the observed value, advanced by the current controls: `exp = f(i_Q, i_en, i_up_down)`, with `i_Q ≥ N` treated as 0. The FSM then returns to CHECK. Sticky flags and `o_err_cnt` are kept.
  - Undefined: FAULT is absorbing until `i_rst`, and the model never reloads from `i_Q`.

## Test plan
- Reset, then `i_en` = 1, up for 5 cycles, with a correct counter (N = 3): `i_Q` = 0,1,2,0,1 and `o_exp` matches → `o_err` = 0, `o_err_cnt` = 0, `o_wrap` pulses once after the 2→0 step.
- Down for 4 cycles starting from 1: sequence 0,2,1,0 → no error, one `o_wrap` after 0→2.
- Force `i_Q` = 2 while `o_exp` = 1 for one cycle → `o_err_pulse` = 1 for exactly one cycle the next cycle, `o_err` = 1, `o_err_cnt` = 1, state FAULT.
- Force `i_Q` = 3 (N = 3) → `o_range_err` = 1 and `o_err` = 1. With `MON_RESYNC_EN`: the model reloads to `f(0, …)`, state returns to CHECK after one cycle, and no further pulses occur if the counter then agrees.
- 20 consecutive mismatching cycles, ERR_W = 4 → `o_err_cnt` saturates at 15.
- Assert `i_rst` for one cycle while in FAULT with `o_err_cnt` = 5 → all outputs 0 after that edge; CHECK from the next edge; a normal count sequence then yields no error.

Source files
------------

// File: rtl/mod_n_count_monitor_if.sv
// Signal bundle between a mod-N counter's controls/output and its cycle-accurate monitor.
interface mod_n_count_monitor_if #(
    parameter int WIDTH = 2,
    parameter int ERR_W = 4
);
    logic             i_en;
    logic             i_up_down;
    logic [WIDTH-1:0] i_Q;
    logic [WIDTH-1:0] o_exp;
    logic             o_err_pulse;
    logic             o_err;
    logic             o_range_err;
    logic [ERR_W-1:0] o_err_cnt;
    logic             o_wrap;
    logic [1:0]       o_state;

    modport master (
        output i_en, i_up_down, i_Q,
        input  o_exp, o_err_pulse, o_err, o_range_err, o_err_cnt, o_wrap, o_state
    );

    modport slave (
        input  i_en, i_up_down, i_Q,
        output o_exp, o_err_pulse, o_err, o_range_err, o_err_cnt, o_wrap, o_state
    );
endinterface

// File: rtl/mod_n_count_monitor.sv
// Reference-model checker for a mod-N up/down counter with sticky and per-cycle error flags.
// Optional macro MON_RESYNC_EN: after a mismatch, reload the model from the observed count.
module mod_n_count_monitor #(
    parameter int WIDTH = 2,
    parameter int N     = 3,
    parameter int ERR_W = 4
) (
    input logic                  i_clk,
    input logic                  i_rst,
    mod_n_count_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_CHECK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] NM1   = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);

    state_t                   state_p1;
    logic [WIDTH-1:0]         exp_p1;
    logic                     err_pulse_p1;
    logic                     err_p1;
    logic                     range_err_p1;
    logic [ERR_W-1:0]         err_cnt_p1;
    logic                     wrap_p1;

    logic                     chk_active;
    logic                     range_hit;
    logic                     mismatch;
    logic [WIDTH-1:0]         base;

    function automatic logic [WIDTH-1:0] step_model(input logic [WIDTH-1:0] cur,
                                                    input logic en, input logic up);
        if (!en)
            return cur;
        if (up)
            return (cur == NM1) ? '0 : cur + 1'b1;
        return (cur == '0) ? NM1 : cur - 1'b1;
    endfunction

    function automatic logic wraps(input logic [WIDTH-1:0] cur, input logic en, input logic up);
        return en && (up ? (cur == NM1) : (cur == '0));
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Compare stage: no checking during the cycle that follows a reset edge.
    always_comb begin
        chk_active = (state_p1 != ST_RST);
        range_hit  = chk_active && ({1'b0, mon.i_Q} >= N_EXT);
        mismatch   = chk_active && ((mon.i_Q != exp_p1) || range_hit);
`ifdef MON_RESYNC_EN
        base = mismatch ? (range_hit ? '0 : mon.i_Q) : exp_p1;
`else
        base = exp_p1;
`endif
    end

    // Register stage: model, flags and FSM all update on the same edge as the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p1     <= ST_RST;
            exp_p1       <= '0;
            err_pulse_p1 <= 1'b0;
            err_p1       <= 1'b0;
            range_err_p1 <= 1'b0;
            err_cnt_p1   <= '0;
            wrap_p1      <= 1'b0;
        end else begin
            exp_p1       <= step_model(base, mon.i_en, mon.i_up_down);
            wrap_p1      <= wraps(base, mon.i_en, mon.i_up_down);
            err_pulse_p1 <= mismatch;
            if (mismatch) begin
                err_p1     <= 1'b1;
                err_cnt_p1 <= sat_inc(err_cnt_p1);
            end
            if (range_hit)
                range_err_p1 <= 1'b1;
            case (state_p1)
                ST_RST:   state_p1 <= ST_CHECK;
                ST_CHECK: state_p1 <= mismatch ? ST_FAULT : ST_CHECK;
`ifdef MON_RESYNC_EN
                ST_FAULT: state_p1 <= ST_CHECK;
`else
                ST_FAULT: state_p1 <= ST_FAULT;
`endif
                default:  state_p1 <= ST_RST;
            endcase
        end
    end

    assign mon.o_exp       = exp_p1;
    assign mon.o_err_pulse = err_pulse_p1;
    assign mon.o_err       = err_p1;
    assign mon.o_range_err = range_err_p1;
    assign mon.o_err_cnt   = err_cnt_p1;
    assign mon.o_wrap      = wrap_p1;
    assign mon.o_state     = state_p1;
endmodule

// File: tb/tb_mod_n_count_monitor.sv
// Directed bench for mod_n_count_monitor (WIDTH=2, N=3, ERR_W=4, default build).
module tb_mod_n_count_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_n_count_monitor_if #(.WIDTH(2), .ERR_W(4)) bus ();

    mod_n_count_monitor #(.WIDTH(2), .N(3), .ERR_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .mon   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic r, input logic en, input logic up, input logic [1:0] q);
        rst           = r;
        bus.i_en      = en;
        bus.i_up_down = up;
        bus.i_Q       = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_exp"},   32'(bus.o_exp), 0);
        chk({tag, "_state"}, 32'(bus.o_state), 0);
        chk({tag, "_pulse"}, 32'(bus.o_err_pulse), 0);
        chk({tag, "_err"},   32'(bus.o_err), 0);
        chk({tag, "_range"}, 32'(bus.o_range_err), 0);
        chk({tag, "_cnt"},   32'(bus.o_err_cnt), 0);
        chk({tag, "_wrap"},  32'(bus.o_wrap), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; bus.i_en = 1'b0; bus.i_up_down = 1'b1; bus.i_Q = 2'd0;
        @(negedge clk);

        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk_all_zero("reset");

        // Up count, correct counter: observed 0,1,2,0,1
        cyc(0, 1, 1, 0);
        chk("rel_state", 32'(bus.o_state), 1);
        chk("rel_exp",   32'(bus.o_exp), 1);
        cyc(0, 1, 1, 1);
        chk("up_exp2", 32'(bus.o_exp), 2);
        chk("up_nowrap", 32'(bus.o_wrap), 0);
        cyc(0, 1, 1, 2);
        chk("up_exp0", 32'(bus.o_exp), 0);
        chk("up_wrap", 32'(bus.o_wrap), 1);
        cyc(0, 1, 1, 0);
        chk("up_wrap_off", 32'(bus.o_wrap), 0);
        cyc(0, 1, 1, 1);
        chk("up_exp", 32'(bus.o_exp), 2);
        chk("up_err", 32'(bus.o_err), 0);
        chk("up_cnt", 32'(bus.o_err_cnt), 0);

        // Down count: observed 2,1,0,2,1
        cyc(0, 1, 0, 2);
        cyc(0, 1, 0, 1);
        chk("dn_exp0", 32'(bus.o_exp), 0);
        cyc(0, 1, 0, 0);
        chk("dn_exp2", 32'(bus.o_exp), 2);
        chk("dn_wrap", 32'(bus.o_wrap), 1);
        cyc(0, 1, 0, 2);
        chk("dn_wrap_off", 32'(bus.o_wrap), 0);
        cyc(0, 1, 0, 1);
        chk("dn_exp", 32'(bus.o_exp), 0);
        chk("dn_err", 32'(bus.o_err), 0);
        chk("dn_state", 32'(bus.o_state), 1);

        // Hold with enable low; comparison still runs and matches
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            chk("hold_exp", 32'(bus.o_exp), 0);
            chk("hold_wrap", 32'(bus.o_wrap), 0);
        end
        chk("hold_err", 32'(bus.o_err), 0);

        // Single mismatch: exp=1, observed 2
        cyc(0, 1, 1, 0);
        chk("pre_mm_exp", 32'(bus.o_exp), 1);
        cyc(0, 0, 1, 2);
        chk("mm_pulse", 32'(bus.o_err_pulse), 1);
        chk("mm_err",   32'(bus.o_err), 1);
        chk("mm_cnt",   32'(bus.o_err_cnt), 1);
        chk("mm_state", 32'(bus.o_state), 2);
        chk("mm_range", 32'(bus.o_range_err), 0);
        cyc(0, 0, 1, 1);
        chk("mm_pulse_off", 32'(bus.o_err_pulse), 0);
        chk("mm_sticky", 32'(bus.o_err), 1);
        chk("mm_fault_hold", 32'(bus.o_state), 2);
        chk("mm_exp_hold", 32'(bus.o_exp), 1);

        // Out-of-range observation
        cyc(0, 0, 1, 3);
        chk("rng_flag",  32'(bus.o_range_err), 1);
        chk("rng_pulse", 32'(bus.o_err_pulse), 1);
        chk("rng_cnt",   32'(bus.o_err_cnt), 2);
        cyc(0, 0, 1, 1);
        chk("rng_sticky", 32'(bus.o_range_err), 1);
        chk("rng_pulse_off", 32'(bus.o_err_pulse), 0);

        // Three more mismatches bring the count to 5, then reset in FAULT
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2);
        chk("cnt5", 32'(bus.o_err_cnt), 5);
        cyc(1, 0, 1, 2);
        chk_all_zero("midrst");

        // Normal count after reset
        cyc(0, 1, 1, 0);
        chk("rr_state", 32'(bus.o_state), 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 2);
        chk("rr_wrap", 32'(bus.o_wrap), 1);
        cyc(0, 1, 1, 0);
        chk("rr_exp", 32'(bus.o_exp), 1);
        chk("rr_err", 32'(bus.o_err), 0);
        chk("rr_state2", 32'(bus.o_state), 1);

        // Saturation: 20 mismatching cycles against exp=1
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 2);
        chk("sat_cnt", 32'(bus.o_err_cnt), 15);
        chk("sat_pulse", 32'(bus.o_err_pulse), 1);
        chk("sat_range", 32'(bus.o_range_err), 0);

        // Simultaneous wrap and mismatch
        cyc(0, 1, 1, 1);
        chk("sim_pre_pulse", 32'(bus.o_err_pulse), 0);
        chk("sim_pre_exp", 32'(bus.o_exp), 2);
        cyc(0, 1, 1, 0);
        chk("sim_wrap",  32'(bus.o_wrap), 1);
        chk("sim_pulse", 32'(bus.o_err_pulse), 1);
        chk("sim_exp",   32'(bus.o_exp), 0);
        chk("sim_cnt",   32'(bus.o_err_cnt), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
